// File: rtl/aes_out_serializer.sv
// aes_out_serializer
//   Captures each 128-bit ciphertext block from the AES core on the rising edge of
//   AES_data_out_valid, buffers it in a DEPTH-slot FIFO, and streams it out as four
//   32-bit words (MSW first) on a valid/ready interface.
//
// Parameters
//   DEPTH      number of 128-bit block slots (power of two, >= 2)
//   BYTE_SWAP  1 = reverse byte order inside each output word
//
// Ports
//   AES_clk, AES_rst_n   clock, asynchronous active-low reset
//   AES_data_out         ciphertext block from the core
//   AES_data_out_valid   core result-valid (level or pulse; rising edge = one push)
//   sout_data/valid/last output word stream, last marks word 3 of a block
//   sout_ready           consumer accepts the current word
//   fifo_level           blocks held, including the one being streamed
//   ovf_flag, ovf_clr    sticky dropped-block flag and its synchronous clear
//   sout_par             (AES_OUT_PARITY_EN only) per-byte XOR of sout_data
//
// Optional feature macro: AES_OUT_PARITY_EN
module aes_out_serializer #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned BYTE_SWAP = 0
) (
    input  logic                         AES_clk,
    input  logic                         AES_rst_n,
    input  logic [127:0]                 AES_data_out,
    input  logic                         AES_data_out_valid,
    output logic [31:0]                  sout_data,
    output logic                         sout_valid,
    input  logic                         sout_ready,
    output logic                         sout_last,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         ovf_flag,
`ifdef AES_OUT_PARITY_EN
    output logic [3:0]                   sout_par,
`endif
    input  logic                         ovf_clr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [127:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;
    logic [1:0]    idx_q;
    logic          valid_d;
    logic          ovf_q;

    logic push, full, out_valid, xfer, pop, accept, drop;

    always_comb begin
        push      = AES_data_out_valid & ~valid_d;
        full      = (count_q == LW'(DEPTH));
        out_valid = (count_q != '0);
        xfer      = out_valid & sout_ready;
        pop       = xfer & (idx_q == 2'd3);
        // A full FIFO that pops this cycle frees the slot being written.
        accept    = push & (~full | pop);
        drop      = push & full & ~pop;
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= 2'd0;
            valid_d  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            valid_d <= AES_data_out_valid;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (xfer) begin
                idx_q <= idx_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (accept && !pop) begin
                count_q <= count_q + LW'(1);
            end else if (pop && !accept) begin
                count_q <= count_q - LW'(1);
            end
            // Set wins over a same-cycle clear.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Block storage needs no reset: its contents are never shown while the FIFO is empty.
    always_ff @(posedge AES_clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= AES_data_out;
        end
    end

    logic [127:0] head;
    logic [31:0]  raw_word;
    logic [31:0]  out_word;

    always_comb begin
        head = mem_q[rd_ptr_q];
        unique case (idx_q)
            2'd0:    raw_word = head[127:96];
            2'd1:    raw_word = head[95:64];
            2'd2:    raw_word = head[63:32];
            default: raw_word = head[31:0];
        endcase
        if (BYTE_SWAP != 0) begin
            out_word = {raw_word[7:0], raw_word[15:8], raw_word[23:16], raw_word[31:24]};
        end else begin
            out_word = raw_word;
        end
    end

    // Outputs are muxed from registered state only; data is forced to zero when idle.
    assign sout_valid = out_valid;
    assign sout_data  = out_valid ? out_word : 32'h0;
    assign sout_last  = out_valid & (idx_q == 2'd3);
    assign fifo_level = count_q;
    assign ovf_flag   = ovf_q;

`ifdef AES_OUT_PARITY_EN
    always_comb begin
        sout_par = 4'h0;
        for (int i = 0; i < 4; i++) begin
            sout_par[i] = ^sout_data[8*i +: 8];
        end
    end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
module tb_aes_out_serializer;

    localparam int unsigned DEPTH = 2;

    logic         AES_clk = 1'b0;
    logic         AES_rst_n;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
    logic         sout_ready;
    logic         ovf_clr;
    logic [31:0]  sout_data, sw_data;
    logic         sout_valid, sw_valid;
    logic         sout_last, sw_last;
    logic [1:0]   fifo_level, sw_level;
    logic         ovf_flag, sw_ovf;

    always #5 AES_clk = ~AES_clk;

    aes_out_serializer #(.DEPTH(DEPTH), .BYTE_SWAP(0)) u_dut (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid),
        .sout_data          (sout_data),
        .sout_valid         (sout_valid),
        .sout_ready         (sout_ready),
        .sout_last          (sout_last),
        .fifo_level         (fifo_level),
        .ovf_flag           (ovf_flag),
        .ovf_clr            (ovf_clr)
    );

    aes_out_serializer #(.DEPTH(DEPTH), .BYTE_SWAP(1)) u_swap (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .AES_data_out       (AES_data_out),
        .AES_data_out_valid (AES_data_out_valid),
        .sout_data          (sw_data),
        .sout_valid         (sw_valid),
        .sout_ready         (sout_ready),
        .sout_last          (sw_last),
        .fifo_level         (sw_level),
        .ovf_flag           (sw_ovf),
        .ovf_clr            (ovf_clr)
    );

    // Reference model: a queue of whole blocks plus the word position inside the head.
    logic [127:0] mq[$];
    int           midx;
    bit           mprev;
    bit           movf;

    logic [31:0]  got[$];
    logic [31:0]  exp_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] word_of(logic [127:0] b, int i);
        return b[127 - 32*i -: 32];
    endfunction

    function automatic logic [31:0] bswap(logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit          v;
        logic [31:0] w;
        v = (mq.size() != 0);
        w = v ? word_of(mq[0], midx) : 32'h0;
        chk("valid",     {127'b0, sout_valid}, {127'b0, v});
        chk("data",      {96'b0, sout_data}, {96'b0, w});
        chk("last",      {127'b0, sout_last}, {127'b0, (v && midx == 3)});
        chk("level",     {126'b0, fifo_level}, 128'(mq.size()));
        chk("ovf",       {127'b0, ovf_flag}, {127'b0, movf});
        chk("swap_data", {96'b0, sw_data}, {96'b0, bswap(w)});
        chk("swap_last", {127'b0, sw_last}, {127'b0, (v && midx == 3)});
    endtask

    // Applies inputs for one cycle, advances the model across the edge, checks at negedge.
    task automatic step(input bit v, input logic [127:0] d, input bit rdy, input bit clr);
        bit mvalid, xfer, pop, push, full;
        AES_data_out_valid = v;
        AES_data_out       = d;
        sout_ready         = rdy;
        ovf_clr            = clr;
        if (sout_valid && rdy) got.push_back(sout_data);
        mvalid = (mq.size() != 0);
        xfer   = mvalid && rdy;
        pop    = xfer && (midx == 3);
        push   = v && !mprev;
        full   = (mq.size() == DEPTH);
        if (xfer) begin
            if (midx == 3) begin
                void'(mq.pop_front());
                midx = 0;
            end else begin
                midx++;
            end
        end
        if (push && full && !pop) movf = 1'b1;
        else if (push)            mq.push_back(d);
        else if (clr)             movf = 1'b0;
        if (push && full && !pop) movf = 1'b1;
        else if (clr && !(push && full && !pop)) movf = 1'b0;
        mprev = v;
        @(posedge AES_clk);
        @(negedge AES_clk);
        check_outputs();
    endtask

    task automatic add_exp(input logic [127:0] b);
        for (int i = 0; i < 4; i++) exp_log.push_back(word_of(b, i));
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, 128'(got.size()), 128'(exp_log.size()));
        for (int i = 0; i < got.size() && i < exp_log.size(); i++)
            chk({tag, "_word"}, {96'b0, got[i]}, {96'b0, exp_log[i]});
        got.delete();
        exp_log.delete();
    endtask

    task automatic model_reset();
        mq.delete();
        midx  = 0;
        mprev = 1'b0;
        movf  = 1'b0;
    endtask

    localparam logic [127:0] BLK = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] BA  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] BB  = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] BC  = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] BD  = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;

    initial begin
        bit r_pat[7];
        logic [127:0] rd;
        AES_rst_n          = 1'b0;
        AES_data_out       = '0;
        AES_data_out_valid = 1'b0;
        sout_ready         = 1'b0;
        ovf_clr            = 1'b0;
        model_reset();
        @(posedge AES_clk);
        @(negedge AES_clk);
        check_outputs();
        AES_rst_n = 1'b1;

        // Single block, ready held high.
        step(1'b1, BLK, 1'b1, 1'b0);
        chk("first_word", {96'b0, sout_data}, {96'b0, 32'h69c4e0d8});
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        add_exp(BLK);
        check_log("single");

        // Backpressure pattern.
        r_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        step(1'b1, BLK, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, r_pat[i], 1'b0);
        add_exp(BLK);
        check_log("backpressure");

        // Level valid: 20 cycles high yields one block.
        for (int i = 0; i < 20; i++) step(1'b1, BA, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        add_exp(BA);
        check_log("level_valid");

        // Overflow with DEPTH=2: C dropped.
        step(1'b1, BA, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, BB, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, BC, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_level", {126'b0, fifo_level}, 128'd2);
        chk("ovf_set", {127'b0, ovf_flag}, 128'd1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
        add_exp(BA);
        add_exp(BB);
        check_log("overflow");
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_cleared", {127'b0, ovf_flag}, 128'd0);

        // Full plus simultaneous pop.
        step(1'b1, BA, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, BB, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, BD, 1'b1, 1'b0);
        chk("fullpop_level", {126'b0, fifo_level}, 128'd2);
        chk("fullpop_ovf", {127'b0, ovf_flag}, 128'd0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 1'b0);
        add_exp(BA);
        add_exp(BB);
        add_exp(BD);
        check_log("fullpop");

        // Reset asserted after word1 has transferred.
        step(1'b1, BC, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        AES_rst_n = 1'b0;
        #1;
        chk("rst_valid", {127'b0, sout_valid}, 128'd0);
        chk("rst_level", {126'b0, fifo_level}, 128'd0);
        chk("rst_data", {96'b0, sout_data}, 128'd0);
        model_reset();
        got.delete();
        @(negedge AES_clk);
        @(negedge AES_clk);
        AES_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_log("after_reset");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            step($urandom_range(0, 2) != 0, rd, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Sits directly downstream of the AES core. Captures each 128-bit ciphertext block when `AES_data_out_valid` rises.
- Buffers captured blocks in a small FIFO.
- Streams each block out as four 32-bit words on a valid/ready interface toward the host/bus side.
- Reports buffer occupancy and a sticky overflow flag when blocks arrive faster than they drain.

Parameters:
- DEPTH, 2, number of 128-bit block slots. Power of two, ≥2.
- BYTE_SWAP, 0, 1 = reverse the byte order within each output word.

Ports:
- AES_clk  in  1  single clock; all state updates on rising edge
- AES_rst_n  in  1  asynchronous active-low reset
- AES_data_out  in  128  ciphertext block from the AES core
- AES_data_out_valid  in  1  core result-valid (level or pulse)
- sout_data  out  32  current output word
- sout_valid  out  1  sout_data is valid
- sout_ready  in  1  consumer accepts the word this cycle
- sout_last  out  1  marks the fourth (final) word of a block
- fifo_level  out  $clog2(DEPTH+1)  number of blocks held, including the one being streamed
- ovf_flag  out  1  sticky: a block was dropped
- ovf_clr  in  1  synchronous clear of ovf_flag

Behaviour:
- Reset (async assert, sync release): FIFO empty, word index 0, valid_d 0.
  - Outputs: sout_valid 0, sout_last 0, sout_data 0, fifo_level 0, ovf_flag 0.
- Capture:
  - valid_d registers AES_data_out_valid. A push event is AES_data_out_valid=1 AND valid_d=0.
  - A valid held high for many cycles therefore yields exactly one push.
  - Valid already high in the first cycle after reset counts as one push.
- Push on a not-full FIFO (or a full FIFO popping this cycle): AES_data_out is written to the write slot and fifo_level increments.
- Push on a full FIFO with no pop this cycle: block dropped, contents unchanged, ovf_flag set.
- ovf_flag: cleared by ovf_clr=1. If set and clear occur in the same cycle, set wins.
- Latency: block pushed at edge N → sout_valid=1 with word 0 from edge N onward (visible in cycle N+1).
- Word order: word0=[127:96], word1=[95:64], word2=[63:32], word3=[31:0]. sout_last=1 only with word3.
- Handshake:
  - A transfer occurs when sout_valid && sout_ready at an edge.
  - While sout_valid=1 and sout_ready=0, sout_data and sout_last hold stable.
  - sout_valid never drops without a transfer, except on reset.
- Word index 0→1→2→3 on each transfer. A transfer at index 3 pops the head block, returns the index to 0 and decrements fifo_level.
- If another block is buffered after a pop, its word0 is presented the next cycle with no bubble.
- Pop and push in the same cycle: fifo_level unchanged and both operations take effect. At full, this push is accepted, not dropped.
- sout_data is registered or muxed from registered state only; no combinational path from AES_data_out to sout_data.
- BYTE_SWAP=1: each output word is byte-reversed. Word order is unchanged.
- Pointers wrap modulo DEPTH. fifo_level saturates at neither end; the push/pop rules above prevent overflow and underflow.
- Reset asserted mid-stream: partial block discarded, all state returns to reset values immediately.

Optional Feature:
- Macro AES_OUT_PARITY_EN.
- Defined: adds output port sout_par [3:0]. sout_par[i] = XOR of byte i of the current sout_data (after any byte swap). It follows the same stability rules as sout_data and resets to 0.
- Not defined: port absent, no parity logic.

Test Plan:
- Single block, ready tied 1: pulse valid one cycle with AES_data_out=69c4e0d8_6a7b0430_d8cdb780_70b4c55a → words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on 4 consecutive cycles, last on the 4th. fifo_level goes 1 then 0; ovf_flag stays 0.
- Backpressure: same block, ready toggling 1,0,0,1,0,1,1 → exactly four transfers, in order. sout_data holds during ready=0 cycles; no duplicated or skipped words.
- Level valid: valid held high 20 cycles with a constant block → exactly one block streamed; fifo_level never exceeds 1.
- Overflow, DEPTH=2, ready=0: three valid rising edges with blocks A, B, C → fifo_level=2 and ovf_flag=1. Raising ready streams A then B with no bubble between them; C is never output. ovf_clr pulse → ovf_flag=0.
- Full plus simultaneous pop: FIFO full (A, B), then ready=1 and a new push (block D) in the same cycle as A's word3 transfer → D accepted, ovf_flag=0, fifo_level stays 2. Output order A, B, D.
- Reset mid-stream: assert AES_rst_n=0 after word1 of a block → sout_valid=0 and fifo_level=0 immediately. After release with no new push, no output appears.
